// File: rtl/tiny_rv_prefetch.sv
// tiny_rv_prefetch: DEPTH-entry instruction prefetch queue with a pipelined request/response memory port.
// Latency: a grant in cycle t with its response in t+k shows on o_valid in t+k+1 (the queue is registered, with no bypass).
// Backpressure: i_pipe_stall holds the head; requests stop once buffered plus in-flight reaches DEPTH. Optional macro TINY_RV_FETCH_ALIGN_CHK_EN.
module tiny_rv_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic        i_ld_new_addr,
  input  logic [31:0] i_new_addr,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output logic        o_valid,
  output logic [31:0] o_fetched_pc,
  output logic [31:0] o_fetched_inst,
  output logic        o_fetch_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;
  localparam logic [CW:0] DEPTH_OCC = (CW+1)'(DEPTH);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] tail_pc_q, tail_pc_d;
  cnt_t        count_q, count_d;
  cnt_t        in_flight_q, in_flight_d;
  cnt_t        drop_q, drop_d;
  ptr_t        rd_ptr_q, rd_ptr_d;
  ptr_t        wr_ptr_q, wr_ptr_d;
  logic        halted_q, halted_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];
`ifdef TINY_RV_FETCH_ALIGN_CHK_EN
  logic        fault_mem [DEPTH];
  logic        push_fault;
  logic        fault_redirect;
`endif

  logic [CW:0] occupancy;
  logic        gnt, pop, accept, discard, restart, push;
  ptr_t        push_idx;
  logic [31:0] push_pc, push_inst, head_pc, restart_tgt, restart_pc;

  // Request gate, handshakes and the restart target (redirect beats flush).
  always_comb begin
    occupancy   = {1'b0, count_q} + {1'b0, in_flight_q};
    o_mem_req   = !i_reset && !halted_q && (occupancy < DEPTH_OCC)
                  && !i_ld_new_addr && !i_pipe_flush;
    o_mem_addr  = fetch_pc_q;
    gnt         = o_mem_req && i_mem_gnt;
    o_valid     = (count_q != '0);
    pop         = o_valid && !i_pipe_stall;
    discard     = i_mem_rvalid && (drop_q != '0);
    accept      = i_mem_rvalid && (drop_q == '0);
    restart     = i_ld_new_addr || i_pipe_flush;
    head_pc     = pc_mem[rd_ptr_q];
    // A flush replays from the oldest PC not yet handed to decode.
    restart_tgt = i_ld_new_addr ? i_new_addr : (o_valid ? head_pc : tail_pc_q);
    restart_pc  = restart_tgt & 32'hFFFF_FFFC;
    in_flight_d = in_flight_q + cnt_t'(gnt) - cnt_t'(i_mem_rvalid);
`ifdef TINY_RV_FETCH_ALIGN_CHK_EN
    fault_redirect = i_ld_new_addr && (i_new_addr[1:0] != 2'b00);
`endif
  end

  // Next-state for fetch pointer, queue bookkeeping and the discard counter.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tail_pc_d  = tail_pc_q;
    count_d    = count_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    halted_d   = halted_q;
    push       = 1'b0;
    push_idx   = wr_ptr_q;
    push_pc    = tail_pc_q;
    push_inst  = i_mem_rdata;
`ifdef TINY_RV_FETCH_ALIGN_CHK_EN
    push_fault = 1'b0;
`endif
    if (restart) begin
      // Everything still outstanding after this edge belongs to the old stream.
      fetch_pc_d = restart_pc;
      tail_pc_d  = restart_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_d     = in_flight_d;
      // Only a redirect releases a halt; a flush replays inside the same stream.
      if (i_ld_new_addr) halted_d = 1'b0;
`ifdef TINY_RV_FETCH_ALIGN_CHK_EN
      if (fault_redirect) begin
        push       = 1'b1;
        push_idx   = '0;
        push_pc    = i_new_addr;
        push_inst  = 32'h0000_0013;
        push_fault = 1'b1;
        count_d    = cnt_t'(1);
        wr_ptr_d   = ptr_t'(1);
        halted_d   = 1'b1;
      end
`endif
    end else begin
      if (gnt) fetch_pc_d = fetch_pc_q + 32'd4;
      if (discard) drop_d = drop_q - cnt_t'(1);
      if (accept) begin
        push      = 1'b1;
        tail_pc_d = tail_pc_q + 32'd4;
        wr_ptr_d  = wr_ptr_q + ptr_t'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + ptr_t'(1);
      count_d = count_q + cnt_t'(accept) - cnt_t'(pop);
    end
  end

  // Control state register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fetch_pc_q  <= RESET_PC;
      tail_pc_q   <= RESET_PC;
      count_q     <= '0;
      in_flight_q <= '0;
      drop_q      <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      halted_q    <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      tail_pc_q   <= tail_pc_d;
      count_q     <= count_d;
      in_flight_q <= in_flight_d;
      drop_q      <= drop_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      halted_q    <= halted_d;
    end
  end

  // Queue payload; validity lives in count_q, so the storage needs no reset.
  always_ff @(posedge i_clk) begin
    if (push) begin
      pc_mem[push_idx]    <= push_pc;
      inst_mem[push_idx]  <= push_inst;
`ifdef TINY_RV_FETCH_ALIGN_CHK_EN
      fault_mem[push_idx] <= push_fault;
`endif
    end
  end

  // Head outputs read as zero whenever the queue is empty.
  always_comb begin
    o_fetched_pc   = o_valid ? head_pc : 32'h0;
    o_fetched_inst = o_valid ? inst_mem[rd_ptr_q] : 32'h0;
`ifdef TINY_RV_FETCH_ALIGN_CHK_EN
    o_fetch_fault  = o_valid && fault_mem[rd_ptr_q];
`else
    o_fetch_fault  = 1'b0;
`endif
  end

endmodule

// File: doc/tiny_rv_prefetch.md
# tiny_rv_prefetch

Parametrised instruction-fetch front end for tiny_rv32 that replaces the single-entry fetch stage with a DEPTH-entry prefetch queue and a pipelined memory request/response port. It sits between instruction memory and decode. It issues in-order word fetches ahead of the pipeline, buffers returned instructions with their PCs, and supports stall, flush (replay), and redirect. Responses still in flight at a flush or redirect are discarded.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- DEPTH, 4, queue entries and maximum in-flight requests; power of two, ≥2
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_pipe_stall  in  1  decode not accepting; head entry is held
- i_pipe_flush  in  1  discard queue and in-flight responses; replay from the oldest undelivered PC
- i_ld_new_addr  in  1  redirect strobe; has priority over i_pipe_flush
- i_new_addr  in  32  redirect target
- o_mem_req  out  1  fetch request valid
- o_mem_addr  out  32  word address of request
- i_mem_gnt  in  1  request accepted this cycle
- i_mem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant
- i_mem_rdata  in  32  response instruction
- o_valid  out  1  head entry valid
- o_fetched_pc  out  32  head PC; 0 when !o_valid
- o_fetched_inst  out  32  head instruction; 0 when !o_valid
- o_fetch_fault  out  1  head entry is a misaligned-target fault (see Configuration)

## Operation
- State: fetch_pc (32), circular queue of {pc, inst, fault}, count, in_flight (all granted, unreturned requests), drop (in-flight responses to discard). Counters are $clog2(DEPTH)+1 bits wide.
- Request: o_mem_req = !i_reset && !halted && (count + in_flight < DEPTH) && !i_ld_new_addr && !i_pipe_flush. o_mem_addr = fetch_pc.
- Grant: fetch_pc += 4 (wraps modulo 2^32); in_flight increments.
- Response: in_flight decrements. If drop>0, drop decrements and the data is discarded. Otherwise push {pc_of_request, i_mem_rdata, 0}. Response PCs are tracked by a tail-PC register that advances by 4 per accepted response.
- Pop: the head is removed when o_valid && !i_pipe_stall.
- Simultaneous push and pop: count is unchanged. A full queue never overflows because the request gate bounds it.
- Redirect (i_ld_new_addr): fetch_pc and tail-PC take {i_new_addr[31:2],2'b00}. The queue is cleared, drop = in_flight (including the same-cycle grant, minus the same-cycle response), and halted clears.
- Flush: same as redirect with target = head PC if o_valid, else tail-PC.
- Stall does not block fetching. The queue fills to DEPTH, then o_mem_req drops.

## Timing
- Reset (async): fetch_pc = tail-PC = RESET_PC, count = in_flight = drop = 0, halted = 0. All outputs are 0.
- First o_mem_req is in the first cycle after i_reset deasserts.
- Grant in cycle t, response in t+k (k≥1): o_valid is in t+k+1. There is no bypass, so the queue is registered.
- Redirect or flush at cycle t: o_valid = 0 and the new o_mem_addr are in t+1. Any response in t is discarded.
- Back-to-back grants with 1-cycle responses and no stall give 1 instruction per cycle.

## Configuration
- TINY_RV_FETCH_ALIGN_CHK_EN defined: a redirect target with i_new_addr[1:0]≠0 issues no request. It pushes one entry {pc=i_new_addr, inst=32'h0000_0013, fault=1} and sets halted. halted stays set until the next redirect or reset.
- Not defined: the target is forced word-aligned and o_fetch_fault is tied 0.

## Test plan
Memory model for all scenarios: always grants and returns inst = addr ^ 32'hA5A5_0000 one cycle after grant, with DEPTH=4 and RESET_PC=0.
- Reset release, no stall: o_valid in cycle 3. The sequence shows PCs 0,4,8,… with inst A5A5_0000, A5A5_0004, …, one per cycle.
- Stall held 10 cycles: the head stays at its PC and o_mem_req drops once count+in_flight=4. After release, 4 buffered entries drain consecutively with no gaps or duplicates.
- Redirect to 32'h6969_6968 with one request in flight: the stale response is dropped. The next o_valid shows PC 6969_6968, inst CCCC_6968.
- Flush while head PC=0x10 and queue full: the queue is emptied, the next request address is 0x10, and delivery resumes at 0x10.
- Redirect and flush asserted together: the redirect target wins.
- With TINY_RV_FETCH_ALIGN_CHK_EN, redirect to 32'h6969_6969: one entry with fault=1, inst 0000_0013, pc 6969_6969, and no o_mem_req until the next redirect.
